// File: rtl/ifetch_pc_unit_pkg.sv
// ============================================================================
//  ifetch_pkg : shared types and constants for the instruction-fetch PC unit
//  Rev 1.0
// ============================================================================
`default_nettype none

package ifetch_pkg;

  localparam logic [31:0] c_PC_INC   = 32'd4;
  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  // Tag is sized for the narrowest legal index; unused upper bits stay zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  function automatic logic [29:0] btb_tag(input logic [31:0] pc, input int bits);
    logic [31:0] w_shifted;
    w_shifted = pc >> (bits + 2);
    return w_shifted[29:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_pc_unit_if.sv
// ============================================================================
//  ifetch_pc_unit_if : fetch-side bus (predictor, IF/ID register, EX feedback)
//  Rev 1.0
// ============================================================================
`default_nettype none

interface ifetch_pc_unit_if #(
  parameter int PHT_BITS = 5
);
  logic [31:0]         pc_if;
  logic                pred_taken_if;
  logic [PHT_BITS-1:0] pht_idx_if;
  logic                id_valid;
  logic                id_ready;
  logic [31:0]         id_pc;
  logic                id_pred_taken;
  logic [31:0]         id_pred_target;
  logic [PHT_BITS-1:0] id_pht_idx;
  logic                ex_redirect;
  logic [31:0]         ex_redirect_pc;
  logic                ex_btb_we;
  logic [31:0]         ex_btb_pc;
  logic [31:0]         ex_btb_target;

  modport master (
    output pc_if, id_valid, id_pc, id_pred_taken, id_pred_target, id_pht_idx,
    input  pred_taken_if, pht_idx_if, id_ready,
    input  ex_redirect, ex_redirect_pc, ex_btb_we, ex_btb_pc, ex_btb_target
  );

  modport slave (
    input  pc_if, id_valid, id_pc, id_pred_taken, id_pred_target, id_pht_idx,
    output pred_taken_if, pht_idx_if, id_ready,
    output ex_redirect, ex_redirect_pc, ex_btb_we, ex_btb_pc, ex_btb_target
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_pc_unit_btb_dm.sv
// ============================================================================
//  btb_dm : direct-mapped BTB, combinational read, one synchronous write port
//  Rev 1.0
// ============================================================================
`default_nettype none

module btb_dm
  import ifetch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int BITS    = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [31:0] i_rd_pc,
  output logic             o_hit,
  output logic [31:0]      o_target,
  input  wire logic        i_we,
  input  wire logic [31:0] i_wr_pc,
  input  wire logic [31:0] i_wr_target
);

  logic [ENTRIES-1:0] r_valid;
  logic [29:0]        r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  logic [BITS-1:0]    w_rd_idx;
  logic [BITS-1:0]    w_wr_idx;
  btb_entry_t         w_rd_entry;

  assign w_rd_idx = i_rd_pc[BITS+1:2];
  assign w_wr_idx = i_wr_pc[BITS+1:2];

  // Read sees pre-write contents; a same-cycle write lands on the next edge.
  assign w_rd_entry = '{valid:  r_valid[w_rd_idx],
                        tag:    r_tag[w_rd_idx],
                        target: r_target[w_rd_idx]};

  assign o_hit    = w_rd_entry.valid && (w_rd_entry.tag == btb_tag(i_rd_pc, BITS));
  assign o_target = w_rd_entry.target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[w_wr_idx]    <= btb_tag(i_wr_pc, BITS);
      r_target[w_wr_idx] <= i_wr_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_pc_unit.sv
// ============================================================================
//  ifetch_pc_unit : fetch PC register, BTB-based next-PC select, IF/ID register
//  Rev 1.0
// ============================================================================
`default_nettype none

module ifetch_pc_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = c_RESET_PC,
  parameter int          BTB_ENTRIES = 16,
  parameter int          BTB_BITS    = 4,
  parameter int          PHT_BITS    = 5
) (
  input wire logic          clk,
  input wire logic          rst_n,
  ifetch_pc_unit_if.master  bus
);

  logic [31:0]         r_pc;
  logic                r_id_valid;
  logic [31:0]         r_id_pc;
  logic                r_id_taken;
  logic [31:0]         r_id_target;
  logic [PHT_BITS-1:0] r_id_pht;

  logic                w_btb_hit;
  logic [31:0]         w_btb_target;
  logic                w_taken_sel;
  logic [31:0]         w_next_pc;
  logic                w_adv;

  btb_dm #(
    .ENTRIES (BTB_ENTRIES),
    .BITS    (BTB_BITS)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_pc     (r_pc),
    .o_hit       (w_btb_hit),
    .o_target    (w_btb_target),
    .i_we        (bus.ex_btb_we),
    .i_wr_pc     (bus.ex_btb_pc),
    .i_wr_target (bus.ex_btb_target)
  );

  assign w_taken_sel = w_btb_hit & bus.pred_taken_if;
  assign w_next_pc   = w_taken_sel ? w_btb_target : (r_pc + c_PC_INC);
  assign w_adv       = !r_id_valid || bus.id_ready;

  // Redirect outranks advance; on redirect the IF/ID payload holds but is invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_id_valid  <= 1'b0;
      r_id_pc     <= '0;
      r_id_taken  <= 1'b0;
      r_id_target <= '0;
      r_id_pht    <= '0;
    end else if (bus.ex_redirect) begin
      r_pc       <= bus.ex_redirect_pc;
      r_id_valid <= 1'b0;
    end else if (w_adv) begin
      r_pc        <= w_next_pc;
      r_id_valid  <= 1'b1;
      r_id_pc     <= r_pc;
      r_id_taken  <= w_taken_sel;
      r_id_target <= w_next_pc;
      r_id_pht    <= bus.pht_idx_if;
    end
  end

  assign bus.pc_if          = r_pc;
  assign bus.id_valid       = r_id_valid;
  assign bus.id_pc          = r_id_pc;
  assign bus.id_pred_taken  = r_id_taken;
  assign bus.id_pred_target = r_id_target;
  assign bus.id_pht_idx     = r_id_pht;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_pc_unit.sv
// ============================================================================
//  tb_ifetch_pc_unit : directed vector table, corner sequences, random vs model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_pc_unit;
  import ifetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ifetch_pc_unit_if #(.PHT_BITS(5)) bus ();

  ifetch_pc_unit #(
    .RESET_PC    (32'h0000_0000),
    .BTB_ENTRIES (16),
    .BTB_BITS    (4),
    .PHT_BITS    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        we;
    logic [31:0] wpc;
    logic [31:0] wtgt;
    logic        rdy;
    logic        pt;
    logic [4:0]  pht;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_idpc;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic [4:0]  e_pht;
  } vec_t;

  vec_t vecs [22];

  // reference model state: BTB kept as full branch PCs, not tag/index fields
  logic        m_bv   [16];
  logic [31:0] m_bpc  [16];
  logic [31:0] m_btgt [16];
  logic [31:0] m_pc;
  logic        m_v;
  logic [31:0] m_idpc;
  logic        m_tk;
  logic [31:0] m_tgt;
  logic [4:0]  m_pht;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic v,
                         input logic [31:0] idpc, input logic tk,
                         input logic [31:0] tgt, input logic [4:0] pht);
    chk({tag, ".pc_if"},          bus.pc_if,          pc);
    chk({tag, ".id_valid"},       32'(bus.id_valid),  32'(v));
    chk({tag, ".id_pc"},          bus.id_pc,          idpc);
    chk({tag, ".id_pred_taken"},  32'(bus.id_pred_taken), 32'(tk));
    chk({tag, ".id_pred_target"}, bus.id_pred_target, tgt);
    chk({tag, ".id_pht_idx"},     32'(bus.id_pht_idx), 32'(pht));
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic we,
                       input logic [31:0] wpc, input logic [31:0] wtgt,
                       input logic rdy, input logic pt, input logic [4:0] pht);
    bus.ex_redirect    = redir;
    bus.ex_redirect_pc = rpc;
    bus.ex_btb_we      = we;
    bus.ex_btb_pc      = wpc;
    bus.ex_btb_target  = wtgt;
    bus.id_ready       = rdy;
    bus.pred_taken_if  = pt;
    bus.pht_idx_if     = pht;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic we,
                              input logic [31:0] wpc, input logic [31:0] wtgt,
                              input logic rdy, input logic pt, input logic [4:0] pht,
                              input logic [31:0] e_pc, input logic e_v,
                              input logic [31:0] e_idpc, input logic e_tk,
                              input logic [31:0] e_tgt, input logic [4:0] e_pht);
    vec_t r;
    r = '{redir, rpc, we, wpc, wtgt, rdy, pt, pht, e_pc, e_v, e_idpc, e_tk, e_tgt, e_pht};
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_bv[i] = 1'b0; m_bpc[i] = '0; m_btgt[i] = '0;
    end
    m_pc = 32'h0; m_v = 1'b0; m_idpc = '0; m_tk = 1'b0; m_tgt = '0; m_pht = '0;
  endtask

  task automatic model_step(input logic redir, input logic [31:0] rpc, input logic we,
                            input logic [31:0] wpc, input logic [31:0] wtgt,
                            input logic rdy, input logic pt, input logic [4:0] pht);
    int unsigned idx;
    int unsigned widx;
    logic        taken;
    logic [31:0] nxt;
    idx   = (m_pc >> 2) % 16;
    taken = pt && m_bv[idx] && (m_bpc[idx][31:2] == m_pc[31:2]);
    nxt   = taken ? m_btgt[idx] : m_pc + 32'd4;
    if (redir) begin
      m_pc = rpc; m_v = 1'b0;
    end else if (!m_v || rdy) begin
      m_idpc = m_pc; m_tk = taken; m_tgt = nxt; m_pht = pht;
      m_pc = nxt; m_v = 1'b1;
    end
    if (we) begin
      widx = (wpc >> 2) % 16;
      m_bv[widx] = 1'b1; m_bpc[widx] = wpc; m_btgt[widx] = wtgt;
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 1) ? 32'h0000_1000 : 32'h0;
    return base | (32'($urandom_range(0, 63)) << 2);
  endfunction

  initial begin
    vecs[0]  = mk(0,0,0,0,0,            1,0, 1, 32'h04,1,32'h00,0,32'h04, 1);
    vecs[1]  = mk(0,0,1,32'h10,32'h100, 1,0, 2, 32'h08,1,32'h04,0,32'h08, 2);
    vecs[2]  = mk(0,0,0,0,0,            1,0, 3, 32'h0C,1,32'h08,0,32'h0C, 3);
    vecs[3]  = mk(0,0,0,0,0,            1,0, 4, 32'h10,1,32'h0C,0,32'h10, 4);
    vecs[4]  = mk(0,0,0,0,0,            1,1, 5, 32'h100,1,32'h10,1,32'h100, 5);
    vecs[5]  = mk(1,32'h10,0,0,0,       1,1, 6, 32'h10,0,32'h10,1,32'h100, 5);
    vecs[6]  = mk(0,0,0,0,0,            1,0, 7, 32'h14,1,32'h10,0,32'h14, 7);
    vecs[7]  = mk(1,32'h50,0,0,0,       1,0, 8, 32'h50,0,32'h10,0,32'h14, 7);
    vecs[8]  = mk(0,0,0,0,0,            1,1, 9, 32'h54,1,32'h50,0,32'h54, 9);
    vecs[9]  = mk(0,0,0,0,0,            0,1,10, 32'h54,1,32'h50,0,32'h54, 9);
    vecs[10] = mk(0,0,0,0,0,            0,0,11, 32'h54,1,32'h50,0,32'h54, 9);
    vecs[11] = mk(0,0,0,0,0,            0,1,12, 32'h54,1,32'h50,0,32'h54, 9);
    vecs[12] = mk(0,0,0,0,0,            1,0,13, 32'h58,1,32'h54,0,32'h58,13);
    vecs[13] = mk(0,0,0,0,0,            0,0,14, 32'h58,1,32'h54,0,32'h58,13);
    vecs[14] = mk(1,32'h200,0,0,0,      0,0,15, 32'h200,0,32'h54,0,32'h58,13);
    vecs[15] = mk(0,0,0,0,0,            0,0,16, 32'h204,1,32'h200,0,32'h204,16);
    vecs[16] = mk(1,32'h20,0,0,0,       1,0,17, 32'h20,0,32'h200,0,32'h204,16);
    vecs[17] = mk(0,0,1,32'h20,32'h300, 1,1,18, 32'h24,1,32'h20,0,32'h24,18);
    vecs[18] = mk(1,32'h20,0,0,0,       1,0,19, 32'h20,0,32'h20,0,32'h24,18);
    vecs[19] = mk(0,0,0,0,0,            1,1,20, 32'h300,1,32'h20,1,32'h300,20);
    vecs[20] = mk(1,32'hFFFF_FFFC,0,0,0,1,0,21, 32'hFFFF_FFFC,0,32'h20,1,32'h300,20);
    vecs[21] = mk(0,0,0,0,0,            1,0,22, 32'h0,1,32'hFFFF_FFFC,0,32'h0,22);

    drive(0,0,0,0,0,0,0,0);
    rst_n = 1'b0;
    tick(); tick();
    chk_all("reset", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].redir, vecs[i].rpc, vecs[i].we, vecs[i].wpc, vecs[i].wtgt,
            vecs[i].rdy, vecs[i].pt, vecs[i].pht);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_v, vecs[i].e_idpc,
              vecs[i].e_tk, vecs[i].e_tgt, vecs[i].e_pht);
    end

    // randomized phase against the reference model
    drive(0,0,0,0,0,0,0,0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic        redir, we, rdy, pt;
      logic [31:0] rpc, wpc, wtgt;
      logic [4:0]  pht;
      redir = ($urandom_range(0, 9) == 0);
      rpc   = rnd_pc();
      we    = ($urandom_range(0, 9) < 3);
      wpc   = ($urandom_range(0, 1) == 1) ? m_pc : rnd_pc();
      wtgt  = rnd_pc();
      rdy   = ($urandom_range(0, 9) < 7);
      pt    = ($urandom_range(0, 3) != 0);
      pht   = 5'($urandom);
      drive(redir, rpc, we, wpc, wtgt, rdy, pt, pht);
      model_step(redir, rpc, we, wpc, wtgt, rdy, pt, pht);
      tick();
      chk_all($sformatf("rnd%0d", n), m_pc, m_v, m_idpc, m_tk, m_tgt, m_pht);
    end

    // asynchronous reset while stalled, then confirm BTB was cleared
    drive(1,32'h40,0,0,0,1,0,0); tick();
    drive(0,0,0,0,0,1,0,0);      tick();
    drive(0,0,0,0,0,0,0,0);      tick();
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
    tick();
    rst_n = 1'b1;
    chk("post_rst.pc_if", bus.pc_if, 32'h0);
    drive(0,0,0,0,0,1,0,5'd3); tick();
    chk_all("first_fetch", 32'h4, 1'b1, 32'h0, 1'b0, 32'h4, 5'd3);
    for (int k = 0; k < 16; k++) begin
      drive(1, 32'(k) << 2, 0,0,0, 1,1,0); tick();
      drive(0,0,0,0,0,1,1,0);             tick();
      chk($sformatf("btb_cleared%0d", k), bus.pc_if, (32'(k) << 2) + 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifetch_pc_unit.md
# ifetch_pc_unit

Instruction-fetch PC generator with a direct-mapped branch target buffer (BTB). Holds the architectural fetch PC, drives it to the gshare predictor, and combines the predictor's direction bit with a BTB hit to pick the next PC. Latches each fetched PC plus its prediction metadata (taken flag, target, PHT index) into the IF/ID register for decode, and accepts redirects and BTB training from EX.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- BTB_ENTRIES, 16, BTB depth; must equal 2**BTB_BITS
- BTB_BITS, 4, BTB index width
- PHT_BITS, 5, predictor index width; must match predictor instance
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_if  out  32  current fetch PC, to predictor and instruction memory
- pred_taken_if  in  1  predictor direction for pc_if
- pht_idx_if  in  PHT_BITS  predictor index for pc_if
- id_valid  out  1  IF/ID register holds a fetched instruction
- id_ready  in  1  decode accepts IF/ID contents this cycle
- id_pc  out  32  PC of IF/ID entry
- id_pred_taken  out  1  entry was predicted taken (BTB hit AND pred_taken_if)
- id_pred_target  out  32  predicted next PC of entry (target or pc+4)
- id_pht_idx  out  PHT_BITS  PHT index, carried to EX for predictor update
- ex_redirect  in  1  EX mispredict / jump: restart fetch
- ex_redirect_pc  in  32  restart address
- ex_btb_we  in  1  write BTB entry
- ex_btb_pc  in  32  branch PC being trained
- ex_btb_target  in  32  resolved target

## Operation
- BTB: BTB_ENTRIES entries of {valid, tag = pc[31:BTB_BITS+2], target[31:0]}; index = pc[BTB_BITS+1:2]. Combinational lookup on pc_if; hit = valid AND tag match.
- Prediction: taken_sel = hit AND pred_taken_if; next_pc = taken_sel ? btb_target : pc_if + 4 (32-bit, wraps modulo 2^32, no overflow flag).
- Advance condition: adv = !id_valid OR id_ready.
- Priority per cycle:
  - ex_redirect: pc_if <= ex_redirect_pc; id_valid <= 0, regardless of adv.
  - else if adv: IF/ID <= {pc_if, taken_sel, next_pc, pht_idx_if}, id_valid <= 1; pc_if <= next_pc.
  - else (stall): pc_if and IF/ID hold.
- BTB write: on ex_btb_we, entry[idx(ex_btb_pc)] <= {1, tag(ex_btb_pc), ex_btb_target}, overwriting any prior entry. Write is independent of redirect/stall. No write-to-read bypass: a lookup of the same index in the write cycle sees old contents.
- BTB entries are never invalidated except by reset.
- Reset (async, rst_n low): pc_if = RESET_PC, id_valid = 0, id_pc/id_pred_target = 0, id_pred_taken = 0, id_pht_idx = 0, all BTB valid = 0. Reset mid-stall or mid-redirect discards everything; first fetch after release is RESET_PC.

## Timing
- pc_if is a register; prediction path (BTB read + predictor + adder + mux) is single-cycle combinational to the pc register.
- Fetch of PC at cycle N -> id_valid with that PC at N+1 (if adv at N).
- Redirect asserted at N -> pc_if = ex_redirect_pc at N+1, id_valid = 0 at N+1, redirect target in IF/ID at N+2: one bubble.
- Predicted-taken branch: zero bubbles; target is pc_if the next cycle.
- Stall (id_valid=1, id_ready=0): all outputs stable until id_ready; pred_taken_if may change meanwhile and is ignored.
- BTB write at N is visible to lookups at N+1.

## Structure
- Shared package ifetch_pkg: BTB entry struct typedef (valid, tag, target), PC increment constant 4, RESET_PC default.
- One sub-module: btb_dm (direct-mapped storage, combinational read port, single synchronous write port, async reset of valid bits). Next-PC logic and IF/ID register stay in ifetch_pc_unit.

## Test plan
- Reset: hold rst_n low, release -> pc_if=0x0, id_valid=0; then with id_ready=1, pc_if steps 0x0,0x4,0x8 and id_pc trails by one cycle.
- BTB hit taken: write {pc 0x10 -> 0x100}, pred_taken_if=1 at pc 0x10 -> next pc_if=0x100, id_pred_taken=1, id_pred_target=0x100; with pred_taken_if=0 -> next pc_if=0x14, id_pred_taken=0.
- Tag miss/alias: BTB holds 0x10 entry, fetch 0x50 (same index, different tag) with pred_taken_if=1 -> next pc_if=0x54.
- Stall: id_valid=1, id_ready=0 for 3 cycles -> pc_if and all id_* stable; id_ready=1 -> advances one entry.
- Redirect during stall: ex_redirect=1, ex_redirect_pc=0x200 while stalled -> next cycle pc_if=0x200, id_valid=0; following cycle id_pc=0x200.
- Write/read collision: ex_btb_we for 0x20 in same cycle pc_if=0x20 -> that cycle predicts 0x24 (old, invalid); refetch of 0x20 later hits.
